// File: rtl/serial_xnor_comparator.sv
// serial_xnor_comparator - bit-serial XNOR comparator, LSB first, start/done handshake
// Builds a per-bit XNOR vector, an equality flag and a count of examined bit pairs.
module serial_xnor_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0,
  localparam int NW        = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             eq,
  output logic [WIDTH-1:0] xnor_vec,
  output logic [NW-1:0]    nbits
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [NW-1:0] LAST_BIT = NW'(WIDTH - 1);
  localparam logic [NW-1:0] ONE      = NW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [NW-1:0]    nbits_q, nbits_d;
  logic             eq_q, eq_d;
  logic             m;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    vec_d   = vec_q;
    nbits_d = nbits_q;
    eq_d    = eq_q;
    m       = ~(sa_q[0] ^ sb_q[0]);
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          vec_d   = '0;
          nbits_d = '0;
          eq_d    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // nbits_q is the index of the bit pair currently at the shifter LSB
        for (int i = 0; i < WIDTH; i++) begin
          if (nbits_q == NW'(i)) vec_d[i] = m;
        end
        eq_d    = eq_q & m;
        nbits_d = nbits_q + ONE;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        if ((nbits_q == LAST_BIT) || (EARLY_EXIT && !m)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      vec_q   <= '0;
      nbits_q <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      vec_q   <= vec_d;
      nbits_q <= nbits_d;
      eq_q    <= eq_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign eq       = eq_q;
  assign xnor_vec = vec_q;
  assign nbits    = nbits_q;

endmodule

// File: tb/tb_serial_xnor_comparator.sv
// tb/tb_serial_xnor_comparator.sv - self-checking bench for serial_xnor_comparator
// Three instances: (8, full scan), (8, early exit), (1, full scan).
module tb_serial_xnor_comparator;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic [7:0] a8 = '0, b8 = '0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic       st [3] = '{1'b0, 1'b0, 1'b0};
  logic       rdy [3];
  logic       dn [3];
  logic       eqw [3];
  logic [7:0] vec0, vec1;
  logic [0:0] vec2;
  logic [3:0] nb0, nb1;
  logic [0:0] nb2;
  logic [63:0] vecw [3];
  logic [63:0] nbw [3];

  assign vecw[0] = {56'b0, vec0};
  assign vecw[1] = {56'b0, vec1};
  assign vecw[2] = {63'b0, vec2};
  assign nbw[0]  = {60'b0, nb0};
  assign nbw[1]  = {60'b0, nb1};
  assign nbw[2]  = {63'b0, nb2};

  serial_xnor_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
    .clock(clock), .reset_(rst_n), .start(st[0]), .a(a8), .b(b8),
    .ready(rdy[0]), .done(dn[0]), .eq(eqw[0]), .xnor_vec(vec0), .nbits(nb0));
  serial_xnor_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
    .clock(clock), .reset_(rst_n), .start(st[1]), .a(a8), .b(b8),
    .ready(rdy[1]), .done(dn[1]), .eq(eqw[1]), .xnor_vec(vec1), .nbits(nb1));
  serial_xnor_comparator #(.WIDTH(1), .EARLY_EXIT(1'b0)) dut2 (
    .clock(clock), .reset_(rst_n), .start(st[2]), .a(a1), .b(b1),
    .ready(rdy[2]), .done(dn[2]), .eq(eqw[2]), .xnor_vec(vec2), .nbits(nb2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: result of comparing a and b over w bits, optionally stopping at first mismatch
  function automatic void ref_cmp(input logic [63:0] av, input logic [63:0] bv, input int w,
                                  input bit ee, output logic e, output logic [63:0] v,
                                  output int n);
    logic [63:0] x, mask;
    x = ~(av ^ bv);
    n = w;
    if (ee) begin
      for (int j = w - 1; j >= 0; j--) if (!x[j]) n = j + 1;
    end
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    v = x & mask;
    e = (v == mask);
  endfunction

  int          wdt [3] = '{8, 8, 1};
  bit          eex [3] = '{1'b0, 1'b1, 1'b0};
  int          cnt [3] = '{0, 0, 0};
  logic        m_eq [3] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] m_vec [3] = '{64'd0, 64'd0, 64'd0};
  int          m_n [3] = '{0, 0, 0};

  // cnt: edges left until idle again; 1 means the done cycle, 0 means ready
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt[i] = 0; m_eq[i] = 1'b0; m_vec[i] = '0; m_n[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt[i] > 0) cnt[i]--;
        else if (st[i]) begin
          logic e; logic [63:0] v; int n;
          if (i < 2) ref_cmp({56'b0, a8}, {56'b0, b8}, wdt[i], eex[i], e, v, n);
          else       ref_cmp({63'b0, a1}, {63'b0, b1}, wdt[i], eex[i], e, v, n);
          m_eq[i] = e; m_vec[i] = v; m_n[i] = n; cnt[i] = n + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ready%0d", i), {63'b0, rdy[i]}, {63'b0, cnt[i] == 0});
      chk($sformatf("done%0d", i), {63'b0, dn[i]}, {63'b0, cnt[i] == 1});
      if (cnt[i] <= 1) begin
        chk($sformatf("eq%0d", i), {63'b0, eqw[i]}, {63'b0, m_eq[i]});
        chk($sformatf("xnor_vec%0d", i), vecw[i], m_vec[i]);
        chk($sformatf("nbits%0d", i), nbw[i], 64'(m_n[i]));
      end
    end
  end

  task automatic drive(input int i, input logic [63:0] av, input logic [63:0] bv, input logic s);
    if (i < 2) begin a8 = av[7:0]; b8 = bv[7:0]; end
    else begin a1 = av[0]; b1 = bv[0]; end
    st[i] = s;
  endtask

  task automatic run_op(input string nm, input int i, input logic [63:0] av, input logic [63:0] bv,
                        input logic e_eq, input logic [63:0] e_vec, input int e_n, input int e_edges);
    int edges;
    @(posedge clock); #2;
    drive(i, av, bv, 1'b1);
    @(posedge clock); edges = 1; #2;
    st[i] = 1'b0;
    forever begin
      @(negedge clock);
      if (dn[i] || edges >= 100) break;
      @(posedge clock);
      edges++;
    end
    chk({nm, "_edges"}, 64'(edges), 64'(e_edges));
    chk({nm, "_eq"}, {63'b0, eqw[i]}, {63'b0, e_eq});
    chk({nm, "_vec"}, vecw[i], e_vec);
    chk({nm, "_nbits"}, nbw[i], 64'(e_n));
  endtask

  initial begin
    int pulses;
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), {63'b0, rdy[i]}, 64'd1);
      chk($sformatf("rst_done%0d", i), {63'b0, dn[i]}, 64'd0);
      chk($sformatf("rst_eq%0d", i), {63'b0, eqw[i]}, 64'd0);
      chk($sformatf("rst_vec%0d", i), vecw[i], 64'd0);
      chk($sformatf("rst_nbits%0d", i), nbw[i], 64'd0);
    end
    repeat (2) @(posedge clock);
    #2 rst_n = 1'b1;

    run_op("t1", 0, 64'hA5, 64'hA5, 1'b1, 64'hFF, 8, 9);
    run_op("t2", 0, 64'hF0, 64'h0F, 1'b0, 64'h00, 8, 9);
    run_op("full_bit0", 0, 64'hA5, 64'hA4, 1'b0, 64'hFE, 8, 9);
    run_op("t3", 1, 64'h13, 64'h17, 1'b0, 64'h03, 3, 4);
    run_op("ee_match", 1, 64'h5A, 64'h5A, 1'b1, 64'hFF, 8, 9);
    run_op("ee_bit7", 1, 64'h00, 64'h80, 1'b0, 64'h7F, 8, 9);
    run_op("ee_bit0", 1, 64'h01, 64'h00, 1'b0, 64'h00, 1, 2);
    run_op("t6_ne", 2, 64'h1, 64'h0, 1'b0, 64'h0, 1, 2);
    run_op("t6_eq", 2, 64'h1, 64'h1, 1'b1, 64'h1, 1, 2);

    // start held high: one operation per idle visit, a changed mid-scan
    @(posedge clock); #2;
    drive(0, 64'h3C, 64'h3C, 1'b1);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (dn[0]) pulses++;
      if (c == 3) a8 = 8'h3D;
    end
    st[0] = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (dn[0]) pulses++;
    end
    chk("t4_pulses", 64'(pulses), 64'd2);
    chk("t4_eq", {63'b0, eqw[0]}, 64'd0);
    chk("t4_vec", vecw[0], 64'hFE);

    // reset while bit 4 is being processed
    @(posedge clock); #2;
    drive(0, 64'h55, 64'h55, 1'b1);
    @(posedge clock); #2;
    st[0] = 1'b0;
    repeat (4) @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ready", {63'b0, rdy[0]}, 64'd1);
    chk("t5_done", {63'b0, dn[0]}, 64'd0);
    chk("t5_eq", {63'b0, eqw[0]}, 64'd0);
    chk("t5_vec", vecw[0], 64'd0);
    chk("t5_nbits", nbw[0], 64'd0);
    @(negedge clock);
    @(posedge clock); #2 rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clock);
      if (dn[0]) pulses++;
    end
    chk("t5_no_done", 64'(pulses), 64'd0);
    run_op("t5_after", 0, 64'hC3, 64'hC3, 1'b1, 64'hFF, 8, 9);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
